axi_lite_slave_ctrl: RTL and testbench

- Parametrised, fully synchronous AXI-Lite slave front-end.
- Converts the five AXI-Lite channels into a simple req/ack backend port for register banks and peripherals on the interconnect.
- Independent write and read FSMs; AW and W accepted in either order.
- Address-range decode (DECERR) and backend timeout (SLVERR), so a dead peripheral never hangs the bus.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/req_timeout_cnt.sv | 37 +++
 rtl/axi_lite_slave_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_axi_lite_slave_ctrl.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared response codes, FSM state encodings and address decode for the AXI-Lite slave front-end.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_REQ  = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_REQ  = 2'd1,
        RD_RESP = 2'd2
    } rd_state_e;

    // Operands are widened past any legal address width so base + size cannot wrap.
    function automatic logic in_range(input logic [64:0] addr,
                                      input logic [64:0] base,
                                      input logic [64:0] size);
        return (addr >= base) && (addr < (base + size));
    endfunction

endpackage

// File: rtl/req_timeout_cnt.sv
// Saturating watchdog for a backend request; expired_o pulses in the
// TIMEOUT_CYCLES-th consecutive cycle that run_i is high.
module req_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic resetn_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = run_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/axi_lite_slave_ctrl.sv
// AXI-Lite slave front-end: independent write/read FSMs bridging to a req/ack
// backend, with address-window decode (DECERR) and backend timeout (SLVERR).
module axi_lite_slave_ctrl
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned ADDR_BASE      = 32'h0000_0000,
    parameter int unsigned ADDR_SIZE      = 32'h0000_1000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,

    input  logic [ADDR_WIDTH-1:0] s_awaddr_i,
    input  logic [2:0]            s_awprot_i,
    input  logic                  s_awvalid_i,
    output logic                  s_awready_o,

    input  logic [DATA_WIDTH-1:0] s_wdata_i,
    input  logic [STRB_WIDTH-1:0] s_wstrb_i,
    input  logic                  s_wvalid_i,
    output logic                  s_wready_o,

    output logic [1:0]            s_bresp_o,
    output logic                  s_bvalid_o,
    input  logic                  s_bready_i,

    input  logic [ADDR_WIDTH-1:0] s_araddr_i,
    input  logic [2:0]            s_arprot_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,

    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [1:0]            s_rresp_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,

    output logic                  wr_req_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic [STRB_WIDTH-1:0] wr_strb_o,
    output logic [2:0]            wr_prot_o,
    input  logic                  wr_ack_i,
    input  logic [1:0]            wr_resp_i,

    output logic                  rd_req_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [2:0]            rd_prot_o,
    input  logic                  rd_ack_i,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic [1:0]            rd_resp_i
);

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return in_range(65'(a), 65'(ADDR_BASE), 65'(ADDR_SIZE));
    endfunction

    wr_state_e             wr_state_q;
    logic                  aw_held_q, w_held_q;
    logic                  awready_q, wready_q, wr_req_q, bvalid_q;
    logic [1:0]            bresp_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [STRB_WIDTH-1:0] wr_strb_q;
    logic [2:0]            wr_prot_q;

    rd_state_e             rd_state_q;
    logic                  arready_q, rd_req_q, rvalid_q;
    logic [1:0]            rresp_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [2:0]            rd_prot_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  aw_hs, w_hs, ar_hs, aw_have, w_have;
    logic                  wr_expired, rd_expired;
    logic [ADDR_WIDTH-1:0] aw_addr_cur;

    assign aw_hs   = s_awvalid_i && awready_q;
    assign w_hs    = s_wvalid_i  && wready_q;
    assign ar_hs   = s_arvalid_i && arready_q;
    assign aw_have = aw_held_q || aw_hs;
    assign w_have  = w_held_q  || w_hs;
    // Decode the address arriving this cycle so the backend req can rise right after the last handshake.
    assign aw_addr_cur = aw_hs ? s_awaddr_i : wr_addr_q;

    req_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wr_timeout (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .run_i     (wr_req_q),
        .expired_o (wr_expired)
    );

    req_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd_timeout (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .run_i     (rd_req_q),
        .expired_o (rd_expired)
    );

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_state_q <= WR_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            wr_req_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            wr_prot_q  <= '0;
        end else begin
            case (wr_state_q)
                WR_IDLE: begin
                    if (aw_hs) begin
                        wr_addr_q <= s_awaddr_i;
                        wr_prot_q <= s_awprot_i;
                        aw_held_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wr_data_q <= s_wdata_i;
                        wr_strb_q <= s_wstrb_i;
                        w_held_q  <= 1'b1;
                    end
                    awready_q <= !aw_have;
                    wready_q  <= !w_have;
                    if (aw_have && w_have) begin
                        if (addr_hit(aw_addr_cur)) begin
                            wr_req_q   <= 1'b1;
                            wr_state_q <= WR_REQ;
                        end else begin
                            bvalid_q   <= 1'b1;
                            bresp_q    <= RESP_DECERR;
                            wr_state_q <= WR_RESP;
                        end
                    end
                end
                WR_REQ: begin
                    if (wr_ack_i) begin
                        wr_req_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= wr_resp_i;
                        wr_state_q <= WR_RESP;
                    end else if (wr_expired) begin
                        wr_req_q   <= 1'b0;
                        bvalid_q   <= 1'b1;
                        bresp_q    <= RESP_SLVERR;
                        wr_state_q <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_bready_i) begin
                        bvalid_q   <= 1'b0;
                        aw_held_q  <= 1'b0;
                        w_held_q   <= 1'b0;
                        awready_q  <= 1'b1;
                        wready_q   <= 1'b1;
                        wr_state_q <= WR_IDLE;
                    end
                end
                default: wr_state_q <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rd_req_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rd_addr_q  <= '0;
            rd_prot_q  <= '0;
            rdata_q    <= '0;
        end else begin
            case (rd_state_q)
                RD_IDLE: begin
                    arready_q <= !ar_hs;
                    if (ar_hs) begin
                        rd_addr_q <= s_araddr_i;
                        rd_prot_q <= s_arprot_i;
                        if (addr_hit(s_araddr_i)) begin
                            rd_req_q   <= 1'b1;
                            rd_state_q <= RD_REQ;
                        end else begin
                            rvalid_q   <= 1'b1;
                            rresp_q    <= RESP_DECERR;
                            rdata_q    <= '0;
                            rd_state_q <= RD_RESP;
                        end
                    end
                end
                RD_REQ: begin
                    if (rd_ack_i) begin
                        rd_req_q   <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rresp_q    <= rd_resp_i;
                        rdata_q    <= rd_data_i;
                        rd_state_q <= RD_RESP;
                    end else if (rd_expired) begin
                        rd_req_q   <= 1'b0;
                        rvalid_q   <= 1'b1;
                        rresp_q    <= RESP_SLVERR;
                        rdata_q    <= '0;
                        rd_state_q <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (s_rready_i) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign s_awready_o = awready_q;
    assign s_wready_o  = wready_q;
    assign s_bvalid_o  = bvalid_q;
    assign s_bresp_o   = bresp_q;
    assign wr_req_o    = wr_req_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign wr_strb_o   = wr_strb_q;
    assign wr_prot_o   = wr_prot_q;

    assign s_arready_o = arready_q;
    assign s_rvalid_o  = rvalid_q;
    assign s_rresp_o   = rresp_q;
    assign s_rdata_o   = rdata_q;
    assign rd_req_o    = rd_req_q;
    assign rd_addr_o   = rd_addr_q;
    assign rd_prot_o   = rd_prot_q;

endmodule

// File: tb/tb_axi_lite_slave_ctrl.sv
// Scenario bench for axi_lite_slave_ctrl: B/R responses are scoreboarded, cycle behaviour checked inline.
module tb_axi_lite_slave_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        wr_req;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic [2:0]  wr_prot;
    logic        wr_ack = 1'b0;
    logic [1:0]  wr_resp = '0;
    logic        rd_req;
    logic [31:0] rd_addr;
    logic [2:0]  rd_prot;
    logic        rd_ack = 1'b0;
    logic [31:0] rd_data = '0;
    logic [1:0]  rd_resp = '0;

    int checks = 0;
    int errors = 0;

    logic [1:0]  exp_b_q[$];
    logic [1:0]  exp_rresp_q[$];
    logic [31:0] exp_rdata_q[$];

    axi_lite_slave_ctrl dut (
        .clk_i       (clk),
        .resetn_i    (resetn),
        .s_awaddr_i  (awaddr),
        .s_awprot_i  (awprot),
        .s_awvalid_i (awvalid),
        .s_awready_o (awready),
        .s_wdata_i   (wdata),
        .s_wstrb_i   (wstrb),
        .s_wvalid_i  (wvalid),
        .s_wready_o  (wready),
        .s_bresp_o   (bresp),
        .s_bvalid_o  (bvalid),
        .s_bready_i  (bready),
        .s_araddr_i  (araddr),
        .s_arprot_i  (arprot),
        .s_arvalid_i (arvalid),
        .s_arready_o (arready),
        .s_rdata_o   (rdata),
        .s_rresp_o   (rresp),
        .s_rvalid_o  (rvalid),
        .s_rready_i  (rready),
        .wr_req_o    (wr_req),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .wr_strb_o   (wr_strb),
        .wr_prot_o   (wr_prot),
        .wr_ack_i    (wr_ack),
        .wr_resp_i   (wr_resp),
        .rd_req_o    (rd_req),
        .rd_addr_o   (rd_addr),
        .rd_prot_o   (rd_prot),
        .rd_ack_i    (rd_ack),
        .rd_data_i   (rd_data),
        .rd_resp_i   (rd_resp)
    );

    always #5 clk = ~clk;

    // Scoreboard consumers: compare at the falling edge preceding each B/R handshake.
    always @(negedge clk) begin
        if (resetn && bvalid && bready) begin
            checks++;
            if (exp_b_q.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected got bresp=%0b required no response", bresp);
            end else begin
                logic [1:0] eb;
                eb = exp_b_q.pop_front();
                if (bresp !== eb) begin
                    errors++;
                    $display("FAIL b_resp got %0b required %0b", bresp, eb);
                end
            end
        end
        if (resetn && rvalid && rready) begin
            checks++;
            if (exp_rresp_q.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected got rresp=%0b rdata=%h required no response", rresp, rdata);
            end else begin
                logic [1:0]  er;
                logic [31:0] ed;
                er = exp_rresp_q.pop_front();
                ed = exp_rdata_q.pop_front();
                if (rresp !== er || rdata !== ed) begin
                    errors++;
                    $display("FAIL r_resp got %0b/%h required %0b/%h", rresp, rdata, er, ed);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_bvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (bvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_rvalid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (rvalid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid, wr_req, rd_req} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 0000000",
                     {awready, wready, arready, bvalid, rvalid, wr_req, rd_req});
        end
        checks++;
        if ({bresp, rresp, rdata, wr_addr, wr_data, wr_strb, wr_prot, rd_addr, rd_prot} !== '0) begin
            errors++;
            $display("FAIL reset_data got rdata=%h wr_addr=%h wr_data=%h rd_addr=%h required all 0",
                     rdata, wr_addr, wr_data, rd_addr);
        end
        resetn = 1'b1;
        step();
        step();
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_release_ready got %b required 111", {awready, wready, arready});
        end
    endtask

    task automatic test_write_same_cycle();
        bit ok;
        awaddr = 32'h10; awprot = 3'b010; awvalid = 1'b1;
        wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
        exp_b_q.push_back(2'b00);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 32'h10 || wr_data !== 32'hDEAD_BEEF
            || wr_strb !== 4'hF || wr_prot !== 3'b010) begin
            errors++;
            $display("FAIL wr_req_cycle1 got req=%b addr=%h data=%h strb=%h prot=%b required 1/10/deadbeef/f/010",
                     wr_req, wr_addr, wr_data, wr_strb, wr_prot);
        end
        wr_ack = 1'b1; wr_resp = 2'b00;
        step();
        wr_ack = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || wr_req !== 1'b0) begin
            errors++;
            $display("FAIL bvalid_cycle2 got bvalid=%b req=%b required 1/0", bvalid, wr_req);
        end
        wait_bvalid(ok);
        bready = 1'b1;
        step();
        bready = 1'b0;
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL b_done got bvalid=%b awready=%b required 0/1", bvalid, awready);
        end
    endtask

    task automatic test_w_before_aw();
        bit ok;
        wdata = 32'h1234; wstrb = 4'b0110; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        checks++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL w_held_ready got wready=%b awready=%b required 0/1", wready, awready);
        end
        step();
        step();
        checks++;
        if (wr_req !== 1'b0) begin
            errors++;
            $display("FAIL w_only_no_req got %b required 0", wr_req);
        end
        wdata = 32'hFFFF_FFFF;
        awaddr = 32'h20; awprot = 3'b000; awvalid = 1'b1;
        exp_b_q.push_back(2'b01);
        step();
        awvalid = 1'b0;
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 32'h20 || wr_data !== 32'h1234 || wr_strb !== 4'b0110) begin
            errors++;
            $display("FAIL w_first_req got req=%b addr=%h data=%h strb=%b required 1/20/1234/0110",
                     wr_req, wr_addr, wr_data, wr_strb);
        end
        step();
        step();
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 32'h20 || wr_data !== 32'h1234) begin
            errors++;
            $display("FAIL wr_req_stable got req=%b addr=%h data=%h required 1/20/1234", wr_req, wr_addr, wr_data);
        end
        wr_ack = 1'b1; wr_resp = 2'b01;
        step();
        wr_ack = 1'b0;
        wait_bvalid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL w_first_bvalid got timeout required bvalid");
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic test_decerr();
        bit ok;
        rd_ack = 1'b1; rd_data = 32'h5555_5555;
        araddr = 32'h2000; arvalid = 1'b1;
        exp_rresp_q.push_back(2'b11); exp_rdata_q.push_back(32'h0);
        step();
        arvalid = 1'b0;
        checks++;
        if (rd_req !== 1'b0 || rvalid !== 1'b1 || rresp !== 2'b11 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL rd_decerr got req=%b rvalid=%b rresp=%b rdata=%h required 0/1/11/0",
                     rd_req, rvalid, rresp, rdata);
        end
        rd_ack = 1'b0;
        rready = 1'b1;
        step();
        rready = 1'b0;
        araddr = 32'h1000; arvalid = 1'b1;
        exp_rresp_q.push_back(2'b11); exp_rdata_q.push_back(32'h0);
        step();
        arvalid = 1'b0;
        checks++;
        if (rd_req !== 1'b0 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rd_decerr_bound got req=%b rvalid=%b required 0/1", rd_req, rvalid);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        awaddr = 32'h2000; awvalid = 1'b1; wdata = 32'h77; wstrb = 4'hF; wvalid = 1'b1;
        exp_b_q.push_back(2'b11);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (wr_req !== 1'b0 || bvalid !== 1'b1 || bresp !== 2'b11) begin
            errors++;
            $display("FAIL wr_decerr got req=%b bvalid=%b bresp=%b required 0/1/11", wr_req, bvalid, bresp);
        end
        wait_bvalid(ok);
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        rd_data = 32'hBAD0_BAD0;
        araddr = 32'h40; arprot = 3'b001; arvalid = 1'b1;
        exp_rresp_q.push_back(2'b10); exp_rdata_q.push_back(32'h0);
        step();
        arvalid = 1'b0;
        cnt = 0;
        while (rd_req === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt != 16 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL rd_timeout_len got %0d cycles rvalid=%b required 16 cycles rvalid=1", cnt, rvalid);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        araddr = 32'hFFC; arprot = 3'b101; arvalid = 1'b1;
        exp_rresp_q.push_back(2'b00); exp_rdata_q.push_back(32'hCAFE_F00D);
        step();
        arvalid = 1'b0;
        checks++;
        if (rd_req !== 1'b1 || rd_addr !== 32'hFFC || rd_prot !== 3'b101) begin
            errors++;
            $display("FAIL rd_req_top got req=%b addr=%h prot=%b required 1/ffc/101", rd_req, rd_addr, rd_prot);
        end
        step();
        rd_ack = 1'b1; rd_data = 32'hCAFE_F00D; rd_resp = 2'b00;
        step();
        rd_ack = 1'b0; rd_data = 32'h0;
        wait_rvalid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rd_ok_rvalid got timeout required rvalid");
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        // Write timeout with no ack at all.
        awaddr = 32'h48; awvalid = 1'b1; wdata = 32'h1; wvalid = 1'b1;
        exp_b_q.push_back(2'b10);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        wait_bvalid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wr_timeout_bvalid got timeout required bvalid");
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        // Ack landing in the expiry cycle must win.
        awaddr = 32'h44; awvalid = 1'b1; wdata = 32'h2; wvalid = 1'b1;
        exp_b_q.push_back(2'b00);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        repeat (15) step();
        checks++;
        if (wr_req !== 1'b1) begin
            errors++;
            $display("FAIL wr_req_16th got %b required 1", wr_req);
        end
        wr_ack = 1'b1; wr_resp = 2'b00;
        step();
        wr_ack = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL ack_beats_timeout got bvalid=%b bresp=%b required 1/00", bvalid, bresp);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
    endtask

    task automatic test_bready_backpressure();
        awaddr = 32'h30; awvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
        exp_b_q.push_back(2'b10);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        wr_ack = 1'b1; wr_resp = 2'b10;
        step();
        wr_ack = 1'b0;
        awaddr = 32'h34; awvalid = 1'b1; wdata = 32'h9999; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bvalid !== 1'b1 || bresp !== 2'b10 || awready !== 1'b0 || wready !== 1'b0) begin
                errors++;
                $display("FAIL b_hold_%0d got bvalid=%b bresp=%b awready=%b wready=%b required 1/10/0/0",
                         i, bvalid, bresp, awready, wready);
            end
            step();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        step();
        bready = 1'b0;
        step();
        checks++;
        if (bvalid !== 1'b0 || wr_req !== 1'b0 || {awready, wready} !== 2'b11) begin
            errors++;
            $display("FAIL b_release got bvalid=%b req=%b ready=%b required 0/0/11",
                     bvalid, wr_req, {awready, wready});
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        araddr = 32'h80; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        rd_ack = 1'b1; rd_data = 32'h1111_2222; rd_resp = 2'b00;
        step();
        rd_ack = 1'b0;
        awaddr = 32'h84; awvalid = 1'b1; wdata = 32'h3; wvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || wr_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state got rvalid=%b wr_req=%b required 1/1", rvalid, wr_req);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata, wr_req, wr_addr,
             wr_data, wr_strb, wr_prot, rd_req, rd_addr, rd_prot} !== '0) begin
            errors++;
            $display("FAIL async_reset got rvalid=%b rdata=%h wr_req=%b wr_addr=%h required all 0",
                     rvalid, rdata, wr_req, wr_addr);
        end
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (rvalid !== 1'b0 || bvalid !== 1'b0 || wr_req !== 1'b0 || {awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL post_reset got rvalid=%b bvalid=%b req=%b ready=%b required 0/0/0/111",
                     rvalid, bvalid, wr_req, {awready, wready, arready});
        end
        awaddr = 32'h88; awvalid = 1'b1; wdata = 32'h4444; wstrb = 4'h3; wvalid = 1'b1;
        exp_b_q.push_back(2'b00);
        step();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== 32'h88 || wr_data !== 32'h4444 || wr_strb !== 4'h3) begin
            errors++;
            $display("FAIL post_reset_req got req=%b addr=%h data=%h strb=%h required 1/88/4444/3",
                     wr_req, wr_addr, wr_data, wr_strb);
        end
        wr_ack = 1'b1; wr_resp = 2'b00;
        step();
        wr_ack = 1'b0;
        wait_bvalid(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL post_reset_bvalid got timeout required bvalid");
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_decerr();
        test_timeout();
        test_bready_backpressure();
        test_reset_mid();
        checks++;
        if (exp_b_q.size() != 0 || exp_rresp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d B / %0d R pending required 0/0",
                     exp_b_q.size(), exp_rresp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
